fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Time-multiplexed FIR controller that shares one external 8x8 unsigned array multiplier across all filter taps. For each accepted input sample it shifts a tap delay line, then steps through the taps one per cycle. Each step drives one sample/coefficient pair into the multiplier and accumulates the 16-bit product. The block sits between the sample source and the filter output stage, and replaces TAPS parallel multipliers with one.

## Interface
Parameters:
- TAPS, 8, number of filter taps (2..16)
- ACC_W, 19, accumulator/output width; must be at least 16 + clog2(TAPS)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_sample  in  8  unsigned input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  tap index for the write
- coef_data  in  8  unsigned coefficient value
- mul_a  out  8  multiplier operand A (sample)
- mul_b  out  8  multiplier operand B (coefficient)
- mul_prod  in  16  multiplier product, combinational from mul_a/mul_b
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  ACC_W  sum over k of x[k]*c[k]
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, MAC, (DRAIN only with the macro), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: x[k]<=x[k-1] for k=TAPS-1..1; x[0]<=in_sample; acc<=0; idx<=0; go to MAC.
- MAC:
  - mul_a=x[idx], mul_b=c[idx].
  - acc<=acc+mul_prod (or +the registered product, see Configuration).
  - idx increments each cycle.
  - After idx==TAPS-1, go to DONE (or DRAIN).
- DONE:
  - out_valid=1 and out_data=acc, both held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- mul_a/mul_b are driven to 0 outside MAC to suppress multiplier toggling.
- Coefficient writes:
  - Accepted only in IDLE.
  - coef_we while busy is silently dropped.
  - coef_addr>=TAPS is ignored.
  - A write and a sample acceptance in the same IDLE cycle are both performed; the sample's MAC pass uses the new coefficient.
- Arithmetic is unsigned. Accumulation wraps modulo 2^ACC_W if ACC_W is undersized.
- Reset values:
  - x[], c[], acc and idx are 0.
  - State is IDLE.
  - in_ready=1, out_valid=0, out_data=0, busy=0, mul_a=0, mul_b=0.
- Reset asserted mid-MAC or in DONE aborts the pass immediately. The pending result is lost, and the delay line and coefficients clear.

## Timing
- Sample accepted at edge N. MAC occupies edges N+1..N+TAPS. out_valid is high from edge N+TAPS+1 (macro off).
- With the macro: one extra cycle; out_valid is high from N+TAPS+2.
- Throughput: one sample per TAPS+2 cycles (TAPS+3 with the macro), assuming out_ready=1.
- in_ready is low from the acceptance edge until the cycle after the output handshake. No input is accepted in the handshake cycle itself.
- out_ready held low stalls in DONE indefinitely with no data loss.

## Configuration
- FIR_MAC_PIPE_EN defined:
  - mul_prod is captured in a product register each MAC cycle and accumulated one cycle later.
  - DRAIN state (one cycle) adds the final product.
  - This breaks the multiplier-to-adder combinational path.
- Undefined: mul_prod is added directly in the same MAC cycle, and there is no DRAIN state.

## Structure
- Package fir_mac_pkg:
  - state enum: IDLE, MAC, DRAIN, DONE.
  - SAMPLE_W=8, COEF_W=8, PROD_W=16.
  - a clog2-based minimum-ACC_W constant function.
- Sub-module fir_tap_bank:
  - holds the delay line and the coefficient register file.
  - shift port, write port, one indexed read port returning {x[idx], c[idx]}.
- The multiplier is instantiated by the parent and wired to mul_a/mul_b/mul_prod.

## Test plan
- Impulse/step: all coefs=1, samples 1,2,3 with out_ready=1 -> out_data 1, 3, 6; out_valid exactly TAPS+1 cycles after each acceptance (TAPS+2 with the macro).
- Full scale: all coefs=255, eight samples of 255 -> eighth result = 520200, no overflow at ACC_W=19.
- Coefficients c=[1,2,0,...,0], samples 10 then 20 -> results 10, then 20*1+10*2 = 40.
- Back-pressure: out_ready low 5 cycles in DONE -> out_data stable, in_ready=0 throughout, in_valid ignored; the result is consumed once when out_ready rises.
- Write while busy: coef_we to tap 0 with value 7 during MAC -> dropped, result unchanged; the same write in IDLE takes effect on the next sample.
- Reset mid-MAC: deassert rst_n at idx=3 -> outputs at their reset values within the same cycle; after release, sample 5 with coefs still 0 -> result 0.

Source files
------------

// File: rtl/fir_mac_pkg.sv
// Shared types and widths for the time-multiplexed FIR MAC sequencer.
package fir_mac_pkg;

  localparam int SAMPLE_W = 8;
  localparam int COEF_W   = 8;
  localparam int PROD_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] x;
    logic [COEF_W-1:0]   c;
  } tap_pair_t;

  // Smallest accumulator that cannot overflow when summing TAPS full-scale products.
  function automatic int min_acc_w(input int taps);
    return PROD_W + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_tap_bank.sv
// Sample delay line plus coefficient register file, with one indexed read port.
module fir_tap_bank
  import fir_mac_pkg::*;
#(
  parameter int TAPS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en_i,
  input  logic [SAMPLE_W-1:0] shift_data_i,
  input  logic                wr_en_i,
  input  logic [3:0]          wr_addr_i,
  input  logic [COEF_W-1:0]   wr_data_i,
  input  logic [3:0]          rd_idx_i,
  output tap_pair_t           rd_data_o
);

  logic [SAMPLE_W-1:0] x_q [TAPS];
  logic [COEF_W-1:0]   c_q [TAPS];

  // NOTE: these arrays are state the filter result depends on, so they are
  // cleared by reset rather than left as uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      if (shift_en_i) begin
        x_q[0] <= shift_data_i;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
      // Addresses at or beyond TAPS match no entry and are dropped.
      if (wr_en_i) begin
        for (int k = 0; k < TAPS; k++) begin
          if (wr_addr_i == 4'(k)) c_q[k] <= wr_data_i;
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (rd_idx_i == 4'(k)) rd_data_o = '{x: x_q[k], c: c_q[k]};
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller sharing one external 8x8 multiplier across all taps.
// Define FIR_MAC_PIPE_EN to register the product and add a DRAIN cycle.
module fir_mac_sequencer
  import fir_mac_pkg::*;
#(
  parameter int TAPS  = 8,
  parameter int ACC_W = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_sample,
  input  logic                coef_we,
  input  logic [3:0]          coef_addr,
  input  logic [7:0]          coef_data,
  output logic [7:0]          mul_a,
  output logic [7:0]          mul_b,
  input  logic [15:0]         mul_prod,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic                busy
);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             accept;
  logic             last_tap;
  tap_pair_t        tap;

`ifdef FIR_MAC_PIPE_EN
  logic [PROD_W-1:0] prod_q, prod_d;
`endif

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign last_tap = (idx_q == 4'(TAPS - 1));
  assign out_data = acc_q;

  fir_tap_bank #(.TAPS(TAPS)) u_tap_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_en_i   (accept),
    .shift_data_i (in_sample),
    .wr_en_i      (coef_we && (state_q == ST_IDLE)),
    .wr_addr_i    (coef_addr),
    .wr_data_i    (coef_data),
    .rd_idx_i     (idx_q),
    .rd_data_o    (tap)
  );

  // NOTE: every signal written here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    mul_a     = '0;
    mul_b     = '0;
`ifdef FIR_MAC_PIPE_EN
    prod_d    = prod_q;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
`ifdef FIR_MAC_PIPE_EN
          prod_d  = '0;
`endif
        end
      end
      ST_MAC: begin
        mul_a = tap.x;
        mul_b = tap.c;
        idx_d = idx_q + 4'd1;
`ifdef FIR_MAC_PIPE_EN
        // prod_q lags one tap; it is zero on the first MAC cycle.
        prod_d = mul_prod;
        acc_d  = acc_q + ACC_W'(prod_q);
        if (last_tap) state_d = ST_DRAIN;
`else
        acc_d  = acc_q + ACC_W'(mul_prod);
        if (last_tap) state_d = ST_DONE;
`endif
      end
`ifdef FIR_MAC_PIPE_EN
      ST_DRAIN: begin
        acc_d   = acc_q + ACC_W'(prod_q);
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
`ifdef FIR_MAC_PIPE_EN
      prod_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
`ifdef FIR_MAC_PIPE_EN
      prod_q  <= prod_d;
`endif
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer; models the external multiplier.
module tb_fir_mac_sequencer;

  localparam int TAPS  = 8;
  localparam int ACC_W = 19;
`ifdef FIR_MAC_PIPE_EN
  localparam int LAT = TAPS + 2;
`else
  localparam int LAT = TAPS + 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_sample = '0;
  logic             coef_we = 1'b0;
  logic [3:0]       coef_addr = '0;
  logic [7:0]       coef_data = '0;
  logic [7:0]       mul_a, mul_b;
  logic [15:0]      mul_prod;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_data;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mul_prod = 16'(mul_a) * 16'(mul_b);

  fir_mac_sequencer #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sample (in_sample),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_prod  (mul_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [7:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(posedge clk);
    #1 coef_we = 1'b0;
    @(negedge clk);
  endtask

  // Starts and ends on a falling edge. hold keeps out_ready low for 5 DONE cycles
  // while offering a stray sample; busy_wr fires a tap-0 write during MAC.
  task automatic run_sample(input string tag, input logic [7:0] s, input logic [7:0] c0,
                            input logic [31:0] exp, input bit hold, input bit busy_wr);
    int cyc = 0;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    out_ready = !hold;
    in_valid  = 1'b1;
    in_sample = s;
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (out_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_mula"}, 32'(mul_a), 32'(s));
        check({tag, "_mulb"}, 32'(mul_b), 32'(c0));
        check({tag, "_busy"}, {in_ready, busy}, 32'b01);
      end
      if (busy_wr && cyc == 2) begin
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd7;
      end
      if (cyc == 3) coef_we = 1'b0;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(LAT));
    check({tag, "_data"}, 32'(out_data), exp);
    check({tag, "_mulidle"}, {mul_a, mul_b}, 32'd0);
    if (hold) begin
      in_valid  = 1'b1;
      in_sample = 8'd99;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check($sformatf("%s_hold%0d", tag, i), {out_valid, in_ready, 12'd0, out_data}, {2'b10, 12'd0, exp[18:0]});
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_post"}, {out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    // Reset state, sampled while held and after release.
    #2;
    check("rst_held", {in_ready, out_valid, busy, 13'd0, mul_a, mul_b}, {3'b100, 29'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out", {in_ready, out_valid, busy}, 32'b100);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_mul", {mul_a, mul_b}, 32'd0);

    // Step: all coefs 1 -> running sums 1, 3, 6.
    for (int k = 0; k < TAPS; k++) write_coef(4'(k), 8'd1);
    run_sample("step1", 8'd1, 8'd1, 32'd1, 1'b0, 1'b0);
    run_sample("step2", 8'd2, 8'd1, 32'd3, 1'b0, 1'b0);
    run_sample("step3", 8'd3, 8'd1, 32'd6, 1'b0, 1'b0);

    // Back-pressure: delay line 4,3,2,1 -> 10, held for five cycles.
    run_sample("bp", 8'd4, 8'd1, 32'd10, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("bp_noextra", {out_valid, busy}, 32'b00);

    // Full scale: 255*255*k for k = 1..8, last 520200.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(4'(k), 8'd255);
    for (int k = 1; k <= 8; k++)
      run_sample($sformatf("full%0d", k), 8'd255, 8'd255, 32'(65025 * k), 1'b0, 1'b0);

    // c = [1,2,0,...]: 10 -> 10, 20 -> 20*1 + 10*2 = 40.
    do_reset();
    write_coef(4'd0, 8'd1);
    write_coef(4'd1, 8'd2);
    run_sample("coef1", 8'd10, 8'd1, 32'd10, 1'b0, 1'b0);
    run_sample("coef2", 8'd20, 8'd1, 32'd40, 1'b0, 1'b0);

    // Write during MAC dropped: 30*1 + 20*2 = 70.
    run_sample("wbusy", 8'd30, 8'd1, 32'd70, 1'b0, 1'b1);
    // Idle write takes effect; addr 10 is out of range and ignored:
    // 40*7 + 30*2 = 340.
    write_coef(4'd0, 8'd7);
    write_coef(4'd10, 8'd5);
    run_sample("widle", 8'd40, 8'd7, 32'd340, 1'b0, 1'b0);

    // Reset mid-MAC at idx 3 (x[3] = 20).
    in_valid  = 1'b1;
    in_sample = 8'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_mula", 32'(mul_a), 32'd20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {in_ready, out_valid, busy}, 32'b100);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_mul", {mul_a, mul_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sample("after_rst", 8'd5, 8'd0, 32'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
